// File: rtl/spi_cmd_ctrl.sv
// Command controller for the SPI slave byte engine: decodes a command byte, then runs burst
// register writes/reads or FIFO streaming reads. Optional macro SPI_CTRL_ECHO_EN enables loopback echo.
module spi_cmd_ctrl #(
   parameter int unsigned ADDR_W     = 4,
   parameter logic [7:0]  FILL_BYTE  = 8'hFF,
   parameter logic [7:0]  EMPTY_BYTE = 8'h00,
   parameter logic [4:0]  STATUS_ID  = 5'b10100
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              frame_idle,
   input  logic [7:0]        rx_data,
   input  logic              rx_ready,
   input  logic              tx_request,
   output logic [7:0]        tx_data,
   output logic              tx_ready,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [7:0]        reg_wdata,
   output logic              reg_we,
   input  logic [7:0]        reg_rdata,
   input  logic [7:0]        fifo_data,
   input  logic              fifo_empty,
   input  logic              fifo_full,
   output logic              fifo_rd_en,
   output logic              underflow
);

   typedef enum logic [2:0] {StCmd, StIgnore, StWr, StRd, StFf} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]        reg_wdata_q, reg_wdata_d;
   logic              reg_we_q, reg_we_d;
   logic              pending_q, pending_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              tx_ready_q, tx_ready_d;
   logic              fifo_rd_en_q, fifo_rd_en_d;
   logic              underflow_q, underflow_d;
   logic              resync_q, resync_d;
   logic              rx_ok;
   logic              uf_set, uf_clear;
   logic              unused_rx;
`ifdef SPI_CTRL_ECHO_EN
   logic [7:0]        echo_q, echo_d;
`endif

   assign unused_rx = ^rx_data;

   // Bytes are dropped while the frame is idle or until a post-reset frame boundary is seen.
   assign rx_ok = rx_ready & ~frame_idle & ~resync_q;

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      wr_addr_d    = wr_addr_q;
      reg_wdata_d  = reg_wdata_q;
      reg_we_d     = 1'b0;
      pending_d    = tx_request & ~pending_q;
      tx_data_d    = tx_data_q;
      tx_ready_d   = 1'b0;
      fifo_rd_en_d = 1'b0;
      resync_d     = resync_q;
      uf_set       = 1'b0;
      uf_clear     = 1'b0;
`ifdef SPI_CTRL_ECHO_EN
      echo_d       = echo_q;
`endif

      if (frame_idle) begin
         state_d  = StCmd;
         resync_d = 1'b0;
      end else if (rx_ok) begin
`ifdef SPI_CTRL_ECHO_EN
         echo_d = rx_data;
`endif
         case (state_q)
            StCmd: begin
               ptr_d = rx_data[ADDR_W-1:0];
               unique case (rx_data[7:6])
                  2'b00: state_d = StIgnore;
                  2'b01: state_d = StWr;
                  2'b10: state_d = StRd;
                  2'b11: state_d = StFf;
               endcase
            end
            StWr: begin
               reg_we_d    = 1'b1;
               wr_addr_d   = ptr_q;
               reg_wdata_d = rx_data;
               ptr_d       = ptr_q + ADDR_W'(1);
            end
            default: ;
         endcase
      end

      // Service a pending request with the state already updated by a coincident command byte.
      if (pending_q) begin
         tx_ready_d = 1'b1;
         if (frame_idle) begin
            tx_data_d = {fifo_empty, fifo_full, underflow_q, STATUS_ID};
            uf_clear  = 1'b1;
         end else if (resync_q) begin
            tx_data_d = FILL_BYTE;
         end else begin
            case (state_q)
               StCmd: begin
                  tx_data_d = {fifo_empty, fifo_full, underflow_q, STATUS_ID};
                  uf_clear  = 1'b1;
               end
               StIgnore, StWr: begin
`ifdef SPI_CTRL_ECHO_EN
                  tx_data_d = echo_q;
`else
                  tx_data_d = FILL_BYTE;
`endif
               end
               StRd: begin
                  tx_data_d = reg_rdata;
                  ptr_d     = ptr_q + ADDR_W'(1);
               end
               StFf: begin
                  if (fifo_empty) begin
                     tx_data_d = EMPTY_BYTE;
                     uf_set    = 1'b1;
                  end else begin
                     tx_data_d    = fifo_data;
                     fifo_rd_en_d = 1'b1;
                  end
               end
               default: tx_data_d = FILL_BYTE;
            endcase
         end
      end

      underflow_d = uf_set | (underflow_q & ~uf_clear);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StCmd;
         ptr_q        <= '0;
         wr_addr_q    <= '0;
         reg_wdata_q  <= 8'h00;
         reg_we_q     <= 1'b0;
         pending_q    <= 1'b0;
         tx_data_q    <= 8'h00;
         tx_ready_q   <= 1'b0;
         fifo_rd_en_q <= 1'b0;
         underflow_q  <= 1'b0;
         resync_q     <= 1'b1;
`ifdef SPI_CTRL_ECHO_EN
         echo_q       <= 8'h00;
`endif
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         wr_addr_q    <= wr_addr_d;
         reg_wdata_q  <= reg_wdata_d;
         reg_we_q     <= reg_we_d;
         pending_q    <= pending_d;
         tx_data_q    <= tx_data_d;
         tx_ready_q   <= tx_ready_d;
         fifo_rd_en_q <= fifo_rd_en_d;
         underflow_q  <= underflow_d;
         resync_q     <= resync_d;
`ifdef SPI_CTRL_ECHO_EN
         echo_q       <= echo_d;
`endif
      end
   end

   // WR never reads, so a write strobe and a read address never compete.
   assign reg_addr   = reg_we_q ? wr_addr_q : ptr_q;
   assign reg_wdata  = reg_wdata_q;
   assign reg_we     = reg_we_q;
   assign tx_data    = tx_data_q;
   assign tx_ready   = tx_ready_q;
   assign fifo_rd_en = fifo_rd_en_q;
   assign underflow  = underflow_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Scoreboard bench for spi_cmd_ctrl: expected tx bytes and register writes are queued when
// stimulus is driven and compared when the DUT pulses tx_ready / reg_we.
module tb_spi_cmd_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       frame_idle;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       tx_request;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic [3:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_we;
   logic [7:0] reg_rdata;
   logic [7:0] fifo_data;
   logic       fifo_empty;
   logic       fifo_full;
   logic       fifo_rd_en;
   logic       underflow;

`ifdef SPI_CTRL_ECHO_EN
   localparam bit Echo = 1'b1;
`else
   localparam bit Echo = 1'b0;
`endif

   always #5 clk = ~clk;

   spi_cmd_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .frame_idle (frame_idle),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .tx_request (tx_request),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready),
      .reg_addr   (reg_addr),
      .reg_wdata  (reg_wdata),
      .reg_we     (reg_we),
      .reg_rdata  (reg_rdata),
      .fifo_data  (fifo_data),
      .fifo_empty (fifo_empty),
      .fifo_full  (fifo_full),
      .fifo_rd_en (fifo_rd_en),
      .underflow  (underflow)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int pops  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Register bank model with two preloaded locations.
   logic [7:0] bank [16];
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) bank[i] <= 8'h00;
         bank[3] <= 8'h55;
         bank[4] <= 8'h66;
      end else if (reg_we) begin
         bank[reg_addr] <= reg_wdata;
      end
   end
   assign reg_rdata = bank[reg_addr];

   // First-word-fall-through FIFO model.
   logic [7:0] fifo_mem [4];
   int         fifo_wr = 0;
   int         fifo_rd = 0;
   always @(posedge clk) if (fifo_rd_en) fifo_rd <= fifo_rd + 1;
   assign fifo_empty = (fifo_rd == fifo_wr);
   assign fifo_data  = fifo_mem[fifo_rd[1:0]];

   logic [7:0]  exp_tx     [$];
   int          exp_tx_cyc [$];
   logic [11:0] exp_wr     [$];
   int          exp_wr_cyc [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (tx_ready === 1'b1) begin
         if (exp_tx.size() == 0) check("tx_unexpected", 32'd1, 32'd0);
         else begin
            check("tx_data", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
            check("tx_latency", cyc, exp_tx_cyc.pop_front());
         end
      end
      if (reg_we === 1'b1) begin
         if (exp_wr.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
         else begin
            check("wr_addr_data", {20'd0, reg_addr, reg_wdata}, {20'd0, exp_wr.pop_front()});
            check("wr_latency", cyc, exp_wr_cyc.pop_front());
         end
      end
      if (fifo_rd_en === 1'b1) pops++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One stimulus cycle plus settling time; queues any expected tx byte and register write.
   task automatic send(input logic rv, input logic [7:0] b, input logic req,
                       input logic [7:0] exp, input logic wr, input logic [3:0] wa);
      tick();
      rx_ready   = rv;
      rx_data    = b;
      tx_request = req;
      if (req) begin
         exp_tx.push_back(exp);
         exp_tx_cyc.push_back(cyc + 2);
      end
      if (wr) begin
         exp_wr.push_back({wa, b});
         exp_wr_cyc.push_back(cyc + 1);
      end
      tick();
      rx_ready   = 1'b0;
      tx_request = 1'b0;
      repeat (3) tick();
   endtask

   int pops_base;

   initial begin
      reset      = 1'b1;
      frame_idle = 1'b1;
      rx_data    = 8'h00;
      rx_ready   = 1'b0;
      tx_request = 1'b0;
      fifo_full  = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      check("rst_tx_data", {24'd0, tx_data}, 32'h0);
      check("rst_tx_ready", {31'd0, tx_ready}, 32'h0);
      check("rst_reg_we", {31'd0, reg_we}, 32'h0);
      check("rst_reg_addr", {28'd0, reg_addr}, 32'h0);
      check("rst_fifo_rd_en", {31'd0, fifo_rd_en}, 32'h0);
      check("rst_underflow", {31'd0, underflow}, 32'h0);

      // Status byte while idle
      send(1'b0, 8'h00, 1'b1, 8'h94, 1'b0, 4'd0);

      // Burst write with pointer wrap
      frame_idle = 1'b0;
      send(1'b1, 8'h4E, 1'b1, Echo ? 8'h4E : 8'hFF, 1'b0, 4'd0);
      send(1'b1, 8'hA1, 1'b1, Echo ? 8'hA1 : 8'hFF, 1'b1, 4'd14);
      send(1'b1, 8'hB2, 1'b1, Echo ? 8'hB2 : 8'hFF, 1'b1, 4'd15);
      send(1'b1, 8'hC3, 1'b0, 8'h00, 1'b1, 4'd0);
      frame_idle = 1'b1;
      repeat (2) tick();

      // Burst read
      frame_idle = 1'b0;
      send(1'b1, 8'h83, 1'b1, 8'h55, 1'b0, 4'd0);
      send(1'b1, 8'h00, 1'b1, 8'h66, 1'b0, 4'd0);
      frame_idle = 1'b1;
      repeat (2) tick();

      // FIFO stream into underflow, then status clears it
      fifo_mem[0] = 8'h11;
      fifo_mem[1] = 8'h22;
      fifo_wr     = 2;
      pops_base   = pops;
      frame_idle  = 1'b0;
      send(1'b1, 8'hC0, 1'b1, 8'h11, 1'b0, 4'd0);
      send(1'b1, 8'h00, 1'b1, 8'h22, 1'b0, 4'd0);
      send(1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 4'd0);
      check("fifo_pops", pops - pops_base, 32'd2);
      check("underflow_set", {31'd0, underflow}, 32'h1);
      frame_idle = 1'b1;
      repeat (2) tick();
      frame_idle = 1'b0;
      send(1'b0, 8'h00, 1'b1, 8'hB4, 1'b0, 4'd0);
      send(1'b0, 8'h00, 1'b1, 8'h94, 1'b0, 4'd0);
      check("underflow_clear", {31'd0, underflow}, 32'h0);
      frame_idle = 1'b1;
      repeat (2) tick();

      // Byte received during frame_idle is dropped
      send(1'b1, 8'h41, 1'b0, 8'h00, 1'b0, 4'd0);
      frame_idle = 1'b0;
      send(1'b1, 8'h42, 1'b0, 8'h00, 1'b0, 4'd0);
      send(1'b1, 8'h99, 1'b0, 8'h00, 1'b1, 4'd2);
      frame_idle = 1'b1;
      repeat (2) tick();

      // Reset mid read burst, resync until frame_idle pulses
      frame_idle = 1'b0;
      send(1'b1, 8'h83, 1'b1, 8'h55, 1'b0, 4'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_reg_addr", {28'd0, reg_addr}, 32'h0);
      check("midrst_tx_data", {24'd0, tx_data}, 32'h0);
      send(1'b1, 8'h45, 1'b1, 8'hFF, 1'b0, 4'd0);
      send(1'b1, 8'h07, 1'b1, 8'hFF, 1'b0, 4'd0);
      frame_idle = 1'b1;
      tick();
      frame_idle = 1'b0;
      send(1'b1, 8'h40, 1'b1, Echo ? 8'h40 : 8'hFF, 1'b0, 4'd0);
      send(1'b1, 8'h07, 1'b0, 8'h00, 1'b1, 4'd0);
      frame_idle = 1'b1;
      repeat (4) tick();

      check("tx_queue_drained", exp_tx.size(), 32'd0);
      check("wr_queue_drained", exp_wr.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_cmd_ctrl.md
Name: spi_cmd_ctrl

Overview:
- Command controller for the SPI slave byte engine.
- Parses each SPI frame as a command byte followed by data bytes, then sequences one of three accesses:
  - burst register writes to an external register bank;
  - burst register reads from that bank;
  - streaming reads from a first-word-fall-through FIFO.
- Answers every transmit-byte request from the slave with a byte in fixed latency, so the slave's shift register is always loaded.
- Sits between the spi slave and the capture FIFO / configuration registers.

Parameters:
- ADDR_W, 4: register address width; the pointer wraps modulo 2^ADDR_W.
- FILL_BYTE, 8'hFF: transmit byte when no data is meaningful.
- EMPTY_BYTE, 8'h00: transmit byte on a FIFO read while the FIFO is empty.
- STATUS_ID, 5'b10100: constant low field of the status byte.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- frame_idle, input, 1: high while the slave is deselected (the slave's reset output).
- rx_data, input, 8: received byte.
- rx_ready, input, 1: one-cycle pulse; rx_data is valid.
- tx_request, input, 1: one-cycle pulse; the slave needs its next transmit byte.
- tx_data, output, 8: byte for the slave; held until the next load.
- tx_ready, output, 1: one-cycle pulse; the slave latches tx_data.
- reg_addr, output, ADDR_W: register bank address.
- reg_wdata, output, 8: register write data.
- reg_we, output, 1: one-cycle write strobe.
- reg_rdata, input, 8: combinational read data at reg_addr.
- fifo_data, input, 8: FIFO head, first-word-fall-through.
- fifo_empty, input, 1: FIFO empty flag.
- fifo_full, input, 1: FIFO full flag.
- fifo_rd_en, output, 1: one-cycle pop.
- underflow, output, 1: sticky; a FIFO read was attempted while empty.

Behaviour:
- Reset values: all outputs 0, state CMD, pointer 0, pending 0.
- Command byte format, cmd[7:6] opcode:
  - 00: NOP, go to IGNORE.
  - 01: WRITE, go to WR.
  - 10: READ, go to RD.
  - 11: FIFO, go to FF.
  - cmd[ADDR_W-1:0] loads the pointer. The remaining bits are ignored.
- States:
  - CMD: the next rx_ready byte is decoded as the command.
  - IGNORE, WR, RD, FF: persist until frame_idle.
  - frame_idle high in any state: return to CMD on the next edge. An rx_ready in the same cycle is discarded.
- Write path (WR): for each rx_ready, the next cycle gives reg_we=1, reg_addr=pointer, reg_wdata=byte, then pointer+1.
- TX pipeline:
  - tx_request sets a pending flag.
  - The cycle after tx_request, the byte is selected using the state as already updated by a coincident rx_ready.
  - tx_data is registered and tx_ready is pulsed exactly 2 cycles after tx_request.
  - A tx_request arriving while a request is pending merges with it: one response only.
- TX byte selection, by state at service time:
  - frame_idle high or state CMD: status byte {fifo_empty, fifo_full, underflow, STATUS_ID}. Sending it clears underflow, unless an underflow is set in the same cycle; set wins.
  - IGNORE or WR: FILL_BYTE.
  - RD: reg_addr=pointer, tx_data=reg_rdata, pointer+1.
  - FF, FIFO not empty: tx_data=fifo_data, fifo_rd_en pulse 1 cycle.
  - FF, FIFO empty: tx_data=EMPTY_BYTE, no pop, underflow set.
- reg_addr mux: a reg_we cycle drives the write pointer, otherwise the pointer. WR never reads, so the two never coincide.
- Pointer arithmetic: the pointer at 2^ADDR_W-1 increments to 0.
- Reset mid-frame: everything returns to reset values immediately. The next rx_ready is treated as a command only once frame_idle has pulsed high.
  - A post-reset sticky "resync" bit holds this state.
  - While resync is set, bytes are ignored and tx returns FILL_BYTE.

Optional Feature:
- Macro SPI_CTRL_ECHO_EN.
- Defined: in WR and IGNORE the transmitted byte is the last byte received in the frame (the command byte for the first one), for host loopback check.
- Undefined: FILL_BYTE is sent; the echo register is absent.

Test Plan:
- Reset, frame_idle=1, tx_request pulse with fifo_empty=1, fifo_full=0 -> tx_ready 2 cycles later, tx_data=8'h94.
- Frame 8'h4E, 8'hA1, 8'hB2, 8'hC3 -> three reg_we pulses:
  - address 14, data A1;
  - address 15, data B2;
  - address 0 (wrap), data C3.
  - Every tx byte returns 8'hFF (8'h4E, A1, B2 with SPI_CTRL_ECHO_EN).
- Bank preloaded with reg[3]=8'h55, reg[4]=8'h66; frame 8'h83 with coincident rx_ready+tx_request -> tx bytes 55 then 66; no reg_we.
- FIFO holding 8'h11, 8'h22; frame 8'hC0 and 3 tx requests:
  - tx bytes 11, 22, 00;
  - two fifo_rd_en pulses, underflow=1.
  - The next frame's status byte has bit5=1; the following status byte has bit5=0.
- rx_ready in the same cycle as frame_idle=1 -> byte discarded; state CMD; the next frame's first byte is decoded as a command.
- reset asserted during an RD burst, then frame_idle pulse and frame 8'h40, 8'h07 -> no access before frame_idle; after it, reg_we at address 0, data 07.
